cascade_slave_responder: RTL
============================

Name: cascade_slave_responder

Overview:
Slave-side counterpart of the cascade buffer. The master drives the in-service level on CAS during the INTA sequence. This block listens to CAS and tracks the two INTA pulses. It decides whether this device was addressed and, if so, drives its vector on the data bus during the second INTA. It sits between the slave's priority resolver/ISR and the data bus buffer, and also serves single (non-cascaded) mode.

Parameters:
TIMEOUT_CYCLES, 64, clk cycles allowed from INTA1 rising edge to INTA2 falling edge before abort
SYNC_STAGES, 2, synchronizer depth for INTA_n and CAS

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high; forces IDLE and clears all outputs
icw_reset  input  1  synchronous re-init (ICW1 write); same effect as reset on next edge
INTA_n  input  1  interrupt acknowledge from CPU, active low, asynchronous
CAS  input  3  cascade lines from master (input only here)
SNGL  input  1  1 = single mode, 0 = cascade
SP_EN  input  1  1 = master, 0 = slave; block disabled when SNGL=0 and SP_EN=1
slave_id  input  3  this slave's ID (ICW3)
int_pending  input  1  priority resolver has an unmasked request
int_level  input  3  highest pending IR level
vector_base  input  5  T7..T3 from ICW2
INT  output  1  interrupt request to master/CPU
data_oe  output  1  enable for data bus drivers
data_out  output  8  vector {vector_base, latched level}
isr_set  output  1  one-cycle strobe: set ISR bit isr_level
isr_level  output  3  level to set/latched level
cas_match  output  1  registered result: this device addressed in current sequence
timeout_err  output  1  one-cycle strobe on aborted sequence

Behaviour:
- active = SNGL | ~SP_EN. When active=0: state held in IDLE, all outputs 0.
- INTA_n and CAS pass through SYNC_STAGES flops. Edges are detected on the synced INTA_n, so edge strobes lag the pin by SYNC_STAGES+1 cycles.
- Reset values: INT=0, data_oe=0, data_out=0, isr_set=0, isr_level=0, cas_match=0, timeout_err=0, state=IDLE, counter=0.
- States: IDLE, INTA1, GAP, INTA2.
- IDLE: INT = registered int_pending (1-cycle latency).
  - On INTA falling edge with int_pending=1: latch int_level into isr_level, clear cas_match, go to INTA1, drop INT.
  - INTA falling edge with int_pending=0 latches level 7 (spurious IR7 behaviour).
- INTA1: each cycle, match_tmp = SNGL | (CAS_sync == slave_id).
  - On INTA rising edge: cas_match <= match_tmp (last sample wins); isr_set pulses 1 cycle if match_tmp; counter <= 0; go to GAP.
- GAP: counter increments each cycle.
  - INTA falling edge: go to INTA2. If cas_match, data_oe=1 and data_out={vector_base, isr_level} from the cycle after the edge detect.
  - counter == TIMEOUT_CYCLES-1 with no edge: timeout_err pulse, cas_match<=0, go to IDLE.
- INTA2: data_oe held for the whole low phase.
  - On INTA rising edge: data_oe=0, data_out=0, cas_match=0, go to IDLE. INT is re-evaluated from the next cycle.
- vector_base and slave_id changes during a sequence take effect only at the next latch point; data_out uses the value at the INTA2 falling edge.
- Simultaneous icw_reset and an INTA edge: icw_reset wins.
- Asynchronous reset mid-sequence releases data_oe immediately, without waiting for a clock edge.
- SP_EN or SNGL switching to master mid-sequence: abort to IDLE next cycle, no timeout_err.
- Counter width = clog2(TIMEOUT_CYCLES); saturates and never wraps.

Decomposition:
- Shared package pic_pkg: state enum (IDLE, INTA1, GAP, INTA2), SPURIOUS_LEVEL=3'd7, cascade ID width 3, vector base width 5.
- One sub-module: pic_sync_edge. It is a parameterized N-flop synchronizer with fall/rise strobes, used for INTA_n. CAS uses a plain synchronizer instance.

Test Plan:
- Slave match: SNGL=0, SP_EN=0, slave_id=3, vector_base=5'h08, int_level=2; pulse INTA with CAS=3 -> isr_set pulse with isr_level=2 after INTA1 rise; data_oe=1, data_out=8'h42 during INTA2 only.
- Slave mismatch: same setup, CAS=5 -> cas_match=0, no isr_set, data_oe stays 0 through both pulses, back to IDLE.
- Single mode: SNGL=1, CAS=x, int_level=6, vector_base=5'h1F -> data_out=8'hFE during INTA2, isr_set level 6.
- Timeout: TIMEOUT_CYCLES=64; INTA1 then no INTA2 for 64 cycles -> timeout_err 1-cycle pulse, cas_match=0, state IDLE, INT follows int_pending again.
- Reset mid-INTA2: assert reset while data_oe=1 -> data_oe=0 before next clk edge; all outputs at reset values.
- Spurious: int_pending drops before INTA1, matched -> isr_level=7, data_out={vector_base,3'd7}; master-mode (SP_EN=1, SNGL=0) -> all outputs 0 throughout.

Source files
------------

// File: rtl/pic_pkg.sv
// pic_pkg: shared types and constants for the cascade slave responder
// State encoding for the INTA handshake, cascade ID / vector base widths,
// and the level reported when no request is pending at the first INTA.
package pic_pkg;

    typedef enum logic [1:0] {IDLE, INTA1, GAP, INTA2} state_t;

    localparam int CAS_W = 3;
    localparam int VB_W  = 5;

    localparam logic [CAS_W-1:0] SPURIOUS_LEVEL = 3'd7;

endpackage

// File: rtl/pic_sync_edge.sv
// pic_sync_edge: N-flop synchronizer for an idle-high strobe with fall/rise detection
// Ports:
//   clk     system clock
//   reset   asynchronous active-high reset (chain preset to the idle-high level)
//   d_i     asynchronous input
//   fall_o  one-cycle strobe on a 1->0 transition of the synchronized input
//   rise_o  one-cycle strobe on a 0->1 transition of the synchronized input
module pic_sync_edge #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic fall_o,
    output logic rise_o
);

    logic [N-1:0] s_q;
    logic         prev_q;

    // Preset high so releasing reset never looks like an INTA falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q    <= '1;
            prev_q <= 1'b1;
        end else begin
            s_q[0] <= d_i;
            for (int i = 1; i < N; i++) s_q[i] <= s_q[i-1];
            prev_q <= s_q[N-1];
        end
    end

    assign fall_o = prev_q & ~s_q[N-1];
    assign rise_o = ~prev_q & s_q[N-1];

endmodule

// File: rtl/cascade_slave_responder.sv
// cascade_slave_responder: slave-side INTA handshake, cascade address match and vector drive
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   icw_reset         synchronous re-init (ICW1 write)
//   INTA_n, CAS       asynchronous acknowledge and cascade lines from the master
//   SNGL, SP_EN       single mode / master select; disabled as a cascaded master
//   slave_id          this slave's cascade ID (ICW3)
//   int_pending       priority resolver has an unmasked request
//   int_level         highest pending IR level
//   vector_base       vector bits T7..T3 (ICW2)
//   INT               interrupt request out
//   data_oe, data_out vector drive onto the data bus during the second INTA
//   isr_set, isr_level ISR set strobe and latched level
//   cas_match         this device addressed in the current sequence
//   timeout_err       strobe when the second INTA never arrives
module cascade_slave_responder
    import pic_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             icw_reset,
    input  logic             INTA_n,
    input  logic [CAS_W-1:0] CAS,
    input  logic             SNGL,
    input  logic             SP_EN,
    input  logic [CAS_W-1:0] slave_id,
    input  logic             int_pending,
    input  logic [2:0]       int_level,
    input  logic [VB_W-1:0]  vector_base,
    output logic             INT,
    output logic             data_oe,
    output logic [7:0]       data_out,
    output logic             isr_set,
    output logic [2:0]       isr_level,
    output logic             cas_match,
    output logic             timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT  = '1;

    state_t           state_q, state_d;
    logic             int_q, int_d;
    logic             data_oe_q, data_oe_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             isr_set_q, isr_set_d;
    logic [2:0]       isr_level_q, isr_level_d;
    logic             cas_match_q, cas_match_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CAS_W-1:0] cas_q [SYNC_STAGES];
    logic             inta_fall, inta_rise, active, match_tmp;

    assign active    = SNGL | ~SP_EN;
    assign match_tmp = SNGL | (cas_q[SYNC_STAGES-1] == slave_id);

    pic_sync_edge #(.N(SYNC_STAGES)) u_inta_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (INTA_n),
        .fall_o (inta_fall),
        .rise_o (inta_rise)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) cas_q[i] <= '0;
        end else begin
            cas_q[0] <= CAS;
            for (int i = 1; i < SYNC_STAGES; i++) cas_q[i] <= cas_q[i-1];
        end
    end

    always_comb begin
        state_d       = state_q;
        int_d         = 1'b0;
        data_oe_d     = data_oe_q;
        data_out_d    = data_out_q;
        isr_set_d     = 1'b0;
        isr_level_d   = isr_level_q;
        cas_match_d   = cas_match_q;
        timeout_err_d = 1'b0;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                int_d = int_pending;
                if (inta_fall) begin
                    // No request left by the first INTA: answer as IR7 like a real 8259.
                    isr_level_d = int_pending ? int_level : SPURIOUS_LEVEL;
                    cas_match_d = 1'b0;
                    int_d       = 1'b0;
                    state_d     = INTA1;
                end
            end
            INTA1: begin
                if (inta_rise) begin
                    cas_match_d = match_tmp;
                    isr_set_d   = match_tmp;
                    cnt_d       = '0;
                    state_d     = GAP;
                end
            end
            GAP: begin
                cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
                if (inta_fall) begin
                    data_oe_d  = cas_match_q;
                    data_out_d = cas_match_q ? {vector_base, isr_level_q} : 8'h00;
                    state_d    = INTA2;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    cas_match_d   = 1'b0;
                    state_d       = IDLE;
                end
            end
            INTA2: begin
                if (inta_rise) begin
                    data_oe_d   = 1'b0;
                    data_out_d  = 8'h00;
                    cas_match_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Re-init and leaving slave/single operation both override any edge this cycle.
        if (icw_reset || !active) begin
            state_d       = IDLE;
            int_d         = 1'b0;
            data_oe_d     = 1'b0;
            data_out_d    = 8'h00;
            isr_set_d     = 1'b0;
            isr_level_d   = 3'd0;
            cas_match_d   = 1'b0;
            timeout_err_d = 1'b0;
            cnt_d         = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            int_q         <= 1'b0;
            data_oe_q     <= 1'b0;
            data_out_q    <= 8'h00;
            isr_set_q     <= 1'b0;
            isr_level_q   <= 3'd0;
            cas_match_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            int_q         <= int_d;
            data_oe_q     <= data_oe_d;
            data_out_q    <= data_out_d;
            isr_set_q     <= isr_set_d;
            isr_level_q   <= isr_level_d;
            cas_match_q   <= cas_match_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign INT         = int_q;
    assign data_oe     = data_oe_q;
    assign data_out    = data_out_q;
    assign isr_set     = isr_set_q;
    assign isr_level   = isr_level_q;
    assign cas_match   = cas_match_q;
    assign timeout_err = timeout_err_q;

endmodule
